// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over req/gnt and
// buffers returned instructions with their PCs in a small prefetch queue for decode.
module fetch_queue_unit #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    DEPTH        = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         imem_req,
   output logic [ADDR_WIDTH-1:0]        imem_addr,
   input  logic                         imem_gnt,
   input  logic                         imem_rvalid,
   input  logic [DATA_WIDTH-1:0]        imem_rdata,
   input  logic                         redirect_valid,
   input  logic [ADDR_WIDTH-1:0]        redirect_pc,
   output logic                         inst_valid,
   input  logic                         inst_ready,
   output logic [DATA_WIDTH-1:0]        inst_data,
   output logic [ADDR_WIDTH-1:0]        inst_pc,
   output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] tag_pc;
   logic                  inflight;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [CW-1:0]         count;
   logic [CW:0]           occupancy;
   logic                  credit;
   logic                  grant;
   logic                  push;
   logic                  pop;

   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

   // Credit looks only at registered occupancy, so a same-cycle pop never frees a slot early.
   assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign credit    = occupancy < (CW+1)'(DEPTH);

   assign imem_req  = rst & credit & ~redirect_valid;
   assign imem_addr = fetch_pc;
   assign grant     = imem_req & imem_gnt;
   assign push      = imem_rvalid & inflight & ~redirect_valid;

   assign inst_valid  = (count != '0);
   assign pop         = inst_valid & inst_ready;
   assign inst_data   = inst_valid ? data_mem[rd_ptr] : '0;
   assign inst_pc     = inst_valid ? pc_mem[rd_ptr]   : '0;
   assign queue_count = count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc <= RESET_VECTOR;
         tag_pc   <= '0;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & ~(ADDR_WIDTH'(3));
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (grant) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            tag_pc   <= fetch_pc;
         end
         inflight <= grant;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // NOTE: queue storage is deliberately not reset; entries are only
   // observable through count, and the outputs are forced to zero when empty.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= imem_rdata;
         pc_mem[wr_ptr]   <= tag_pc;
      end
   end

endmodule
